// File: rtl/vector_load_store_unit_pkg.sv
// Shared widths, FSM state encoding and command record for the vector load/store unit.
// Imported by the address generator and the top-level sequencer.
package vector_load_store_unit_pkg;

  localparam int DATA_FIELD_WIDTH = 32;
  localparam int ADDR_FIELD_WIDTH = 16;
  localparam int BYTE             = 8;
  localparam int WE_W             = DATA_FIELD_WIDTH / BYTE;

  localparam int MAX_VLEN  = 64;
  localparam int NUM_VREGS = 8;
  localparam int VREG_W    = $clog2(NUM_VREGS);
  localparam int LEN_W     = $clog2(MAX_VLEN + 1);
  localparam int IDX_W     = $clog2(MAX_VLEN);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } vls_state_e;

  typedef struct packed {
    logic                        store;
    logic [ADDR_FIELD_WIDTH-1:0] base;
    logic [ADDR_FIELD_WIDTH-1:0] stride;
    logic [LEN_W-1:0]            len;
    logic [VREG_W-1:0]           vreg;
  } vls_cmd_t;

  // Requests longer than a vector register are truncated to a full register.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_VLEN)) ? LEN_W'(MAX_VLEN) : len;
  endfunction

endpackage

// File: rtl/vector_addr_gen.sv
// Element address accumulator (base + k*stride) with element counter.
// load starts a new vector; step advances one element and holds on the last one.
module vector_addr_gen
  import vector_load_store_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        step,
  input  logic [ADDR_FIELD_WIDTH-1:0] base,
  input  logic [ADDR_FIELD_WIDTH-1:0] stride,
  input  logic [LEN_W-1:0]            len,
  output logic [ADDR_FIELD_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]            idx,
  output logic                        last
);

  logic [ADDR_FIELD_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]            idx_q,  idx_d;
  logic [LEN_W-1:0]            len_q,  len_d;

  // A zero len_q makes len_q-1 all ones, which no index reaches.
  assign last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign addr = addr_q;
  assign idx  = idx_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    addr_d = addr_q;
    idx_d  = idx_q;
    len_d  = len_q;
    if (load) begin
      addr_d = base;
      idx_d  = '0;
      len_d  = len;
    end else if (step && !last) begin
      addr_d = addr_q + stride;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      addr_q <= '0;
      idx_q  <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/vector_load_store_unit.sv
// Sequences one vector load or store into per-element word accesses on a
// single-port memory, absorbing the memory's one-cycle registered read.
module vector_load_store_unit
  import vector_load_store_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_store,
  input  logic [ADDR_FIELD_WIDTH-1:0] cmd_base,
  input  logic [ADDR_FIELD_WIDTH-1:0] cmd_stride,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic [VREG_W-1:0]           cmd_vreg,
  output logic                        done,
  output logic [VREG_W-1:0]           vrf_rd_reg,
  output logic [IDX_W-1:0]            vrf_rd_idx,
  input  logic [DATA_FIELD_WIDTH-1:0] vrf_rd_data,
  output logic                        vrf_wr_en,
  output logic [VREG_W-1:0]           vrf_wr_reg,
  output logic [IDX_W-1:0]            vrf_wr_idx,
  output logic [DATA_FIELD_WIDTH-1:0] vrf_wr_data,
  output logic                        mem_write,
  output logic [WE_W-1:0]             mem_we,
  output logic [ADDR_FIELD_WIDTH-1:0] mem_addr,
  output logic [DATA_FIELD_WIDTH-1:0] mem_data,
  input  logic [DATA_FIELD_WIDTH-1:0] mem_q
);

  vls_state_e                  state_q, state_d;
  logic [ADDR_FIELD_WIDTH-1:0] stride_q, stride_d;
  logic [VREG_W-1:0]           vreg_q, vreg_d;
  logic                        wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]            wb_idx_q, wb_idx_d;

  vls_cmd_t                    cmd_in;
  logic                        gen_load, gen_step, gen_last;
  logic [ADDR_FIELD_WIDTH-1:0] gen_addr;
  logic [IDX_W-1:0]            gen_idx;

  always_comb begin
    cmd_in        = '0;
    cmd_in.store  = cmd_store;
    cmd_in.base   = cmd_base;
    cmd_in.stride = cmd_stride;
    cmd_in.len    = clamp_len(cmd_len);
    cmd_in.vreg   = cmd_vreg;
  end

  // The generator is only reloaded for non-empty commands so mem_addr keeps its last value.
  vector_addr_gen u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (gen_load),
    .step   (gen_step),
    .base   (cmd_in.base),
    .stride (stride_q),
    .len    (cmd_in.len),
    .addr   (gen_addr),
    .idx    (gen_idx),
    .last   (gen_last)
  );

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    vreg_d     = vreg_q;
    wb_valid_d = 1'b0;
    wb_idx_d   = '0;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    mem_write  = 1'b0;
    mem_we     = '0;
    mem_data   = '0;
    vrf_rd_idx = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          stride_d = cmd_in.stride;
          vreg_d   = cmd_in.vreg;
          gen_load = (cmd_in.len != '0);
          if (cmd_in.len == '0)  state_d = DONE;
          else if (cmd_in.store) state_d = STORE;
          else                   state_d = LOAD;
        end
      end
      STORE: begin
        mem_write  = 1'b1;
        mem_we     = '1;
        mem_data   = vrf_rd_data;
        vrf_rd_idx = gen_idx;
        gen_step   = 1'b1;
        if (gen_last) state_d = DONE;
      end
      LOAD: begin
        // Read data returns next cycle; remember which element it belongs to.
        gen_step   = 1'b1;
        wb_valid_d = 1'b1;
        wb_idx_d   = gen_idx;
        if (gen_last) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      stride_q   <= '0;
      vreg_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      stride_q   <= stride_d;
      vreg_q     <= vreg_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
    end
  end

  assign mem_addr    = gen_addr;
  assign vrf_rd_reg  = vreg_q;
  assign vrf_wr_reg  = vreg_q;
  assign vrf_wr_en   = wb_valid_q;
  assign vrf_wr_idx  = wb_idx_q;
  assign vrf_wr_data = wb_valid_q ? mem_q : '0;

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Randomized self-checking bench: word memory and VRF models around the DUT,
// plus a reference model working on whole vectors with plain address arithmetic.
module tb_vector_load_store_unit;
  import vector_load_store_unit_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        cmd_valid, cmd_ready, cmd_store;
  logic [ADDR_FIELD_WIDTH-1:0] cmd_base, cmd_stride;
  logic [LEN_W-1:0]            cmd_len;
  logic [VREG_W-1:0]           cmd_vreg;
  logic                        done;
  logic [VREG_W-1:0]           vrf_rd_reg, vrf_wr_reg;
  logic [IDX_W-1:0]            vrf_rd_idx, vrf_wr_idx;
  logic [DATA_FIELD_WIDTH-1:0] vrf_rd_data, vrf_wr_data;
  logic                        vrf_wr_en, mem_write;
  logic [WE_W-1:0]             mem_we;
  logic [ADDR_FIELD_WIDTH-1:0] mem_addr;
  logic [DATA_FIELD_WIDTH-1:0] mem_data, mem_q;

  int checks = 0;
  int errors = 0;

  logic [DATA_FIELD_WIDTH-1:0] mem     [0:(1<<ADDR_FIELD_WIDTH)-1];
  logic [DATA_FIELD_WIDTH-1:0] ref_mem [0:(1<<ADDR_FIELD_WIDTH)-1];
  logic [DATA_FIELD_WIDTH-1:0] vrf     [0:NUM_VREGS-1][0:MAX_VLEN-1];
  logic [DATA_FIELD_WIDTH-1:0] ref_vrf [0:NUM_VREGS-1][0:MAX_VLEN-1];
  logic                        init_phase = 1'b0;

  always #5 clk = ~clk;

  vector_load_store_unit dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len), .cmd_vreg(cmd_vreg),
    .done(done),
    .vrf_rd_reg(vrf_rd_reg), .vrf_rd_idx(vrf_rd_idx), .vrf_rd_data(vrf_rd_data),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_reg(vrf_wr_reg), .vrf_wr_idx(vrf_wr_idx),
    .vrf_wr_data(vrf_wr_data),
    .mem_write(mem_write), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  // Single-port memory with registered read, and a VRF with combinational read.
  always @(posedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < (1<<ADDR_FIELD_WIDTH); i++) mem[i] <= ref_mem[i];
      for (int r = 0; r < NUM_VREGS; r++)
        for (int e = 0; e < MAX_VLEN; e++) vrf[r][e] <= ref_vrf[r][e];
    end else begin
      if (mem_write) begin
        for (int b = 0; b < WE_W; b++)
          if (mem_we[b]) mem[mem_addr][b*BYTE +: BYTE] <= mem_data[b*BYTE +: BYTE];
      end else begin
        mem_q <= mem[mem_addr];
      end
      if (vrf_wr_en) vrf[vrf_wr_reg][vrf_wr_idx] <= vrf_wr_data;
    end
  end

  assign vrf_rd_data = vrf[vrf_rd_reg][vrf_rd_idx];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_FIELD_WIDTH-1:0] elem_addr(
      input logic [ADDR_FIELD_WIDTH-1:0] base, input logic [ADDR_FIELD_WIDTH-1:0] stride,
      input int k);
    logic [31:0] full;
    full = 32'(base) + 32'(stride) * 32'(k);
    return full[ADDR_FIELD_WIDTH-1:0];
  endfunction

  // Issue one command, watch every cycle until done, then check end state against the model.
  task automatic run_cmd(input bit st, input logic [ADDR_FIELD_WIDTH-1:0] base,
                         input logic [ADDR_FIELD_WIDTH-1:0] stride, input int len,
                         input int vreg, input bit hold);
    int n, exp_done, waited, wcnt, rcnt, c;
    bit seen;
    n        = (len > MAX_VLEN) ? MAX_VLEN : len;
    exp_done = (n == 0) ? 1 : (st ? n + 1 : n + 2);
    cmd_store  = st;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_len    = LEN_W'(len);
    cmd_vreg   = VREG_W'(vreg);
    cmd_valid  = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    wcnt = 0; rcnt = 0; seen = 1'b0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) cmd_valid = 1'b0;
      if (!st && c <= n) begin
        check("ld_nowrite", 64'(mem_write), 64'd0);
        check("ld_addr", 64'(mem_addr), 64'(elem_addr(base, stride, c - 1)));
      end
      if (mem_write) begin
        if (st && wcnt < n) begin
          check("st_we", 64'(mem_we), 64'({WE_W{1'b1}}));
          check("st_addr", 64'(mem_addr), 64'(elem_addr(base, stride, wcnt)));
          check("st_data", 64'(mem_data), 64'(ref_vrf[vreg][wcnt]));
          check("st_cycle", 64'(c), 64'(wcnt + 1));
        end else begin
          check("spurious_write", 64'(mem_write), 64'd0);
        end
        wcnt++;
      end
      if (vrf_wr_en) begin
        if (!st && rcnt < n) begin
          check("wb_reg", 64'(vrf_wr_reg), 64'(vreg));
          check("wb_idx", 64'(vrf_wr_idx), 64'(rcnt));
          check("wb_data", 64'(vrf_wr_data), 64'(ref_mem[elem_addr(base, stride, rcnt)]));
          check("wb_cycle", 64'(c), 64'(rcnt + 2));
        end else begin
          check("spurious_vrf_wr", 64'(vrf_wr_en), 64'd0);
        end
        rcnt++;
      end
      if (done) begin
        check("done_cycle", 64'(c), 64'(exp_done));
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    check("write_count", 64'(wcnt), 64'(st ? n : 0));
    check("vrf_wr_count", 64'(rcnt), 64'(st ? 0 : n));
    @(negedge clk);
    check("ready_after", 64'(cmd_ready), 64'd1);
    // Reference model: whole-vector effect in element order.
    for (int k = 0; k < n; k++) begin
      if (st) ref_mem[elem_addr(base, stride, k)] = ref_vrf[vreg][k];
      else    ref_vrf[vreg][k] = ref_mem[elem_addr(base, stride, k)];
    end
    for (int k = 0; k < n; k++) begin
      if (st) check("mem_final", 64'(mem[elem_addr(base, stride, k)]),
                    64'(ref_mem[elem_addr(base, stride, k)]));
      else    check("vrf_final", 64'(vrf[vreg][k]), 64'(ref_vrf[vreg][k]));
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0;
    cmd_base = '0; cmd_stride = '0; cmd_len = '0; cmd_vreg = '0;
    for (int i = 0; i < (1<<ADDR_FIELD_WIDTH); i++) ref_mem[i] = $urandom;
    for (int r = 0; r < NUM_VREGS; r++)
      for (int e = 0; e < MAX_VLEN; e++) ref_vrf[r][e] = $urandom;
    ref_vrf[2][0] = 32'hAAAA_0001; ref_vrf[2][1] = 32'hBBBB_0002;
    ref_vrf[2][2] = 32'hCCCC_0003; ref_vrf[2][3] = 32'hDDDD_0004;
    init_phase = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_phase = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_vrf_wr_en", 64'(vrf_wr_en), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_selects", 64'({vrf_rd_reg, vrf_rd_idx, vrf_wr_reg, vrf_wr_idx}), 64'd0);

    run_cmd(1'b1, 16'h0010, 16'd1, 4, 2, 1'b0);
    check("store_A", 64'(mem[16'h0010]), 64'h0000_0000_AAAA_0001);
    check("store_D", 64'(mem[16'h0013]), 64'h0000_0000_DDDD_0004);
    run_cmd(1'b0, 16'h0020, 16'd2, 3, 5, 1'b0);
    run_cmd(1'b1, 16'hFFFF, 16'd1, 2, 3, 1'b0);
    run_cmd(1'b0, 16'hFFFF, 16'd1, 2, 4, 1'b0);
    run_cmd(1'b1, 16'h0002, 16'hFFFF, 3, 0, 1'b0);
    run_cmd(1'b0, 16'h0002, 16'hFFFF, 3, 1, 1'b0);
    run_cmd(1'b1, 16'h0100, 16'd1, 0, 2, 1'b0);
    run_cmd(1'b0, 16'h0200, 16'd1, MAX_VLEN + 5, 3, 1'b0);

    for (int t = 0; t < 14; t++) begin
      logic [ADDR_FIELD_WIDTH-1:0] stride;
      stride = ($urandom_range(0, 3) == 0) ? ADDR_FIELD_WIDTH'($urandom)
                                           : ADDR_FIELD_WIDTH'($urandom_range(0, 8) - 4);
      run_cmd(1'($urandom_range(0, 1)), ADDR_FIELD_WIDTH'($urandom), stride,
              $urandom_range(0, MAX_VLEN + 6), $urandom_range(0, 5), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Store then load of the same region with cmd_valid never dropping.
    run_cmd(1'b1, 16'h0300, 16'd1, 6, 1, 1'b1);
    run_cmd(1'b0, 16'h0300, 16'd1, 6, 6, 1'b0);
    for (int k = 0; k < 6; k++) check("b2b_roundtrip", 64'(vrf[6][k]), 64'(ref_vrf[1][k]));

    // Reset while the load of element 3 of 8 is being issued.
    cmd_store = 1'b0; cmd_base = 16'h0400; cmd_stride = 16'd1; cmd_len = LEN_W'(8);
    cmd_vreg = VREG_W'(7); cmd_valid = 1'b1;
    check("rstmid_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    for (c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    check("rstmid_addr3", 64'(mem_addr), 64'h0403);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rstmid_no_wr", 64'(vrf_wr_en), 64'd0);
      check("rstmid_no_done", 64'(done), 64'd0);
      check("rstmid_no_mem_write", 64'(mem_write), 64'd0);
      @(negedge clk);
    end
    check("rstmid_ready_after", 64'(cmd_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_load_store_unit.md
# vector_load_store_unit

Initiator side of the single-port word memory: accepts one vector load or store command and turns it into a sequence of per-element memory accesses at base + k*stride. Loads move read data into the vector register file (VRF); stores move VRF data into memory with full byte enables. It sits between the vector issue logic and the memory's write/we/addr/data/q port. It also absorbs the memory's one-cycle registered-read latency.

## Interface
- MAX_VLEN, 64: maximum elements per command; longer cmd_len is clamped to MAX_VLEN.
- NUM_VREGS, 8: number of vector registers; VREG_W = $clog2(NUM_VREGS).
- LEN_W, $clog2(MAX_VLEN+1): width of length fields; IDX_W = $clog2(MAX_VLEN).
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_store  in  1  1 = store (VRF->mem), 0 = load (mem->VRF).
- cmd_base  in  ADDR_FIELD_WIDTH  word address of element 0.
- cmd_stride  in  ADDR_FIELD_WIDTH  word stride, two's complement.
- cmd_len  in  LEN_W  element count.
- cmd_vreg  in  VREG_W  source/destination vector register.
- done  out  1  one-cycle pulse when the command completes.
- vrf_rd_reg / vrf_rd_idx  out  VREG_W / IDX_W  store read select.
- vrf_rd_data  in  DATA_FIELD_WIDTH  combinational read data for the current select.
- vrf_wr_en  out  1  load write strobe.
- vrf_wr_reg / vrf_wr_idx  out  VREG_W / IDX_W  load write select.
- vrf_wr_data  out  DATA_FIELD_WIDTH  load write data.
- mem_write  out  1  to memory write.
- mem_we  out  DATA_FIELD_WIDTH/BYTE  to memory byte enables.
- mem_addr  out  ADDR_FIELD_WIDTH  to memory address.
- mem_data  out  DATA_FIELD_WIDTH  to memory write data.
- mem_q  in  DATA_FIELD_WIDTH  memory read data, valid the cycle after a read address with mem_write=0.

## Operation
- Reset values: state IDLE; cmd_ready=1 after reset deasserts; done=0, vrf_wr_en=0; mem_write=0, mem_we=0, mem_addr=0, mem_data=0; all select outputs 0.
- States:
  - IDLE: accepts on cmd_valid&&cmd_ready and latches all cmd fields.
  - Accept transitions by command: len==0 -> DONE; store -> STORE; load -> LOAD.
  - STORE: issues element k per cycle; mem_write=1, mem_we all ones, mem_addr=addr_k, mem_data=vrf_rd_data, vrf_rd_idx=k. After element len-1 -> DONE.
  - LOAD: issues read element k per cycle with mem_write=0, mem_addr=addr_k. After element len-1 -> DRAIN.
  - DRAIN: captures the final read; -> DONE.
  - DONE: done=1 for one cycle; -> IDLE.
- Load writeback: in the cycle after element k is issued, vrf_wr_en=1, vrf_wr_idx=k, vrf_wr_data=mem_q. This applies in LOAD (k≥1) and in DRAIN.
- Address: addr_0=base; addr_{k+1}=addr_k+stride, truncated to ADDR_FIELD_WIDTH.
  - Wrap-around is modulo 2^ADDR_FIELD_WIDTH; no error.
  - Negative stride and stride 0 are legal.
- Outside STORE/LOAD: mem_write=0 and mem_we=0. mem_addr holds its last value; that is harmless because the memory only captures the read address.
- Reset mid-command: the command is abandoned next edge, with no further mem_write or vrf_wr_en and no done pulse.
- cmd_valid outside IDLE is ignored; there is no queuing.

## Timing
- Accept at edge T, length N≥1 (clamped).
- Store: mem writes in cycles T+1..T+N; done at T+N+1; cmd_ready at T+N+2.
- Load: reads issued T+1..T+N; VRF writes T+2..T+N+1; done at T+N+2; cmd_ready at T+N+3.
- N=0: done at T+1, with no memory or VRF activity.
- Throughput: one element per cycle; back-to-back commands have a 1-cycle IDLE gap.

## Structure
- Shared package holds:
  - DATA_FIELD_WIDTH, ADDR_FIELD_WIDTH, BYTE.
  - The state enum typedef (IDLE, STORE, LOAD, DRAIN, DONE).
  - A packed vls_cmd_t struct of the cmd fields.
- One sub-module: vector_addr_gen, the base/stride accumulator plus element counter. It has load/step inputs and outputs addr, idx and last.

## Test plan
- Store base=0x10, stride=1, len=4, VRF v2 = {A,B,C,D}: memory 0x10..0x13 = A..D; done at T+5; mem_we all ones every write cycle.
- Load base=0x20, stride=2, len=3, memory pre-loaded: v5[0..2] = mem[0x20], mem[0x22], mem[0x24]; VRF writes T+2..T+4; done at T+5.
- Wrap and negative stride: base=max addr, stride=+1, len=2 hits max then 0. base=2, stride=-1 (all ones), len=3 hits 2, 1, 0.
- len=0 -> done at T+1, no mem_write, no vrf_wr_en. len=MAX_VLEN+5 -> exactly MAX_VLEN elements.
- Reset asserted during LOAD element 3 of 8: no vrf_wr_en or done afterward; IDLE with cmd_ready=1 after reset.
- Store then immediate load of the same region: load returns stored values, with cmd_valid held high throughout.
